// File: rtl/w5300_cmd_sequencer.sv
// Request queue and bus-cycle sequencer in front of the W5300 bus interface block.
// Keeps the interface busy with dummy reads when no host request is waiting.
module w5300_cmd_sequencer #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [9:0]  IDLE_ADDR  = 10'h000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [9:0]  req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic        rsp_wr,
    output logic [15:0] rsp_data,
    output logic [15:0] txn_cnt,
    output logic        init_done,
    output logic [10:0] ctrl_addr,
    output logic [15:0] ctrl_wr_data,
    input  logic [15:0] ctrl_rd_data,
    input  logic        ctrl_op_state
);

    localparam int   AW    = $clog2(FIFO_DEPTH);
    localparam int   EW    = 27;
    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [EW-1:0] fifo_mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_reg, rd_ptr_reg;
    logic          full, empty, push, pop;
    logic [EW-1:0] head;

    logic          nxt_op, nxt_dummy;
    logic [9:0]    nxt_addr;
    logic [15:0]   nxt_wdata;

    logic          cur_op_reg, cur_dummy_reg, inflight_reg;
    logic [9:0]    cur_addr_reg;
    logic [15:0]   cur_wdata_reg;

    logic          rsp_valid_reg, rsp_wr_reg, init_done_reg;
    logic [15:0]   rsp_data_reg, txn_cnt_reg;

    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign push  = req_valid && !full;
    assign pop   = ctrl_op_state && !empty;
    assign head  = fifo_mem[rd_ptr_reg[AW-1:0]];

    // Queue storage carries no reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg[AW-1:0]] <= {req_wr, req_addr, req_wdata};
        end
    end

    always_comb begin
        nxt_op    = OP_RD;
        nxt_addr  = IDLE_ADDR;
        nxt_wdata = 16'h0000;
        nxt_dummy = 1'b1;
        if (!empty) begin
            nxt_op    = head[26];
            nxt_addr  = head[25:16];
            nxt_wdata = head[15:0];
            nxt_dummy = 1'b0;
        end
    end

    // During Idle the interface samples the upcoming cycle; afterwards hold the launched one.
    always_comb begin
        ctrl_addr    = {cur_op_reg, cur_addr_reg};
        ctrl_wr_data = cur_wdata_reg;
        if (ctrl_op_state) begin
            ctrl_addr    = {nxt_op, nxt_addr};
            ctrl_wr_data = nxt_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            cur_op_reg    <= OP_RD;
            cur_addr_reg  <= IDLE_ADDR;
            cur_wdata_reg <= 16'h0000;
            cur_dummy_reg <= 1'b1;
            inflight_reg  <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_wr_reg    <= 1'b0;
            rsp_data_reg  <= 16'h0000;
            txn_cnt_reg   <= 16'h0000;
            init_done_reg <= 1'b0;
        end else begin
            rsp_valid_reg <= 1'b0;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            if (ctrl_op_state) begin
                init_done_reg <= 1'b1;
                cur_op_reg    <= nxt_op;
                cur_addr_reg  <= nxt_addr;
                cur_wdata_reg <= nxt_wdata;
                cur_dummy_reg <= nxt_dummy;
                inflight_reg  <= 1'b1;
                // The Idle edge also closes the previous bus cycle; report it unless it was filler.
                if (inflight_reg && !cur_dummy_reg) begin
                    rsp_valid_reg <= 1'b1;
                    rsp_wr_reg    <= (cur_op_reg == OP_WR);
                    rsp_data_reg  <= (cur_op_reg == OP_WR) ? 16'h0000 : ctrl_rd_data;
                    txn_cnt_reg   <= txn_cnt_reg + 16'h0001;
                end
            end
        end
    end

    assign req_ready = !full;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_wr    = rsp_wr_reg;
    assign rsp_data  = rsp_data_reg;
    assign txn_cnt   = txn_cnt_reg;
    assign init_done = init_done_reg;

endmodule

// File: tb/tb_w5300_cmd_sequencer.sv
// Directed bench for w5300_cmd_sequencer with a cycle-level model of the W5300 bus interface.
module tb_w5300_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wr = 1'b0;
    logic [9:0]  req_addr = 10'h000;
    logic [15:0] req_wdata = 16'h0000;
    logic        rsp_valid;
    logic        rsp_wr;
    logic [15:0] rsp_data;
    logic [15:0] txn_cnt;
    logic        init_done;
    logic [10:0] ctrl_addr;
    logic [15:0] ctrl_wr_data;
    logic [15:0] ctrl_rd_data = 16'h0000;
    logic        ctrl_op_state = 1'b0;

    int total = 0;
    int bad = 0;

    w5300_cmd_sequencer #(.FIFO_DEPTH(4), .IDLE_ADDR(10'h000)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_wr(rsp_wr), .rsp_data(rsp_data),
        .txn_cnt(txn_cnt), .init_done(init_done),
        .ctrl_addr(ctrl_addr), .ctrl_wr_data(ctrl_wr_data),
        .ctrl_rd_data(ctrl_rd_data), .ctrl_op_state(ctrl_op_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] addr;
        logic [15:0] wdata;
        bit          stable;
    } launch_t;
    typedef struct {
        logic        wr;
        logic [15:0] data;
        logic [15:0] cnt;
        int          cyc;
    } rsp_t;

    launch_t launches[$];
    rsp_t    rsps[$];
    int      cyc = 0;
    int      ph = 0;
    logic    prev_op = 1'b0;

    // Interface model plus monitor: sample DUT outputs first, then advance the model inputs.
    always @(negedge clk) begin
        cyc++;
        if (rsp_valid === 1'b1) rsps.push_back('{rsp_wr, rsp_data, txn_cnt, cyc});
        if (rst_n && !ctrl_op_state) begin
            if (prev_op) begin
                launches.push_back('{ctrl_addr, ctrl_wr_data, 1'b1});
            end else if (launches.size() > 0) begin
                int last;
                last = launches.size() - 1;
                if (launches[last].addr !== ctrl_addr || launches[last].wdata !== ctrl_wr_data)
                    launches[last].stable = 1'b0;
            end
            ctrl_rd_data = {6'h0, ctrl_addr[9:0]};
        end
        prev_op = ctrl_op_state;
        if (!rst_n) begin
            ph = 0;
            ctrl_op_state = 1'b0;
        end else begin
            ph++;
            ctrl_op_state = (ph >= 20) && (((ph - 20) % 7) == 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        req_valid = 1'b0;
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    // Returns with the Idle edge just behind us.
    task automatic wait_idle();
        int n;
        n = 0;
        while (ctrl_op_state !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        total++;
        if (ctrl_op_state !== 1'b1) begin
            bad++;
            $display("FAIL wait_idle: got no idle pulse within %0d cycles, required one", n);
        end
    endtask

    task automatic push(input logic wr, input logic [9:0] addr, input logic [15:0] data,
                        output int waited);
        waited = 0;
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = data;
        while (req_ready !== 1'b1 && waited < 30) begin
            tick();
            waited++;
        end
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_rsps(input int n, input int budget);
        int c;
        c = 0;
        while (rsps.size() < n && c < budget) begin
            tick();
            c++;
        end
        total++;
        if (rsps.size() < n) begin
            bad++;
            $display("FAIL rsp_timeout: got %0d responses, required %0d", rsps.size(), n);
        end
    endtask

    task automatic test_reset();
        int c;
        rst_n = 1'b0;
        repeat (2) tick();
        total += 8;
        if (req_ready !== 1'b1)       begin bad++; $display("FAIL rst_req_ready: got %b required 1", req_ready); end
        if (rsp_valid !== 1'b0)       begin bad++; $display("FAIL rst_rsp_valid: got %b required 0", rsp_valid); end
        if (rsp_wr !== 1'b0)          begin bad++; $display("FAIL rst_rsp_wr: got %b required 0", rsp_wr); end
        if (rsp_data !== 16'h0)       begin bad++; $display("FAIL rst_rsp_data: got %h required 0000", rsp_data); end
        if (txn_cnt !== 16'h0)        begin bad++; $display("FAIL rst_txn_cnt: got %h required 0000", txn_cnt); end
        if (init_done !== 1'b0)       begin bad++; $display("FAIL rst_init_done: got %b required 0", init_done); end
        if (ctrl_addr !== 11'h000)    begin bad++; $display("FAIL rst_ctrl_addr: got %h required 000", ctrl_addr); end
        if (ctrl_wr_data !== 16'h0)   begin bad++; $display("FAIL rst_ctrl_wr_data: got %h required 0000", ctrl_wr_data); end
        launches.delete();
        rsps.delete();
        rst_n = 1'b1;
        repeat (10) tick();
        total++;
        if (init_done !== 1'b0) begin bad++; $display("FAIL init_early: got %b required 0", init_done); end
        c = 0;
        while (launches.size() < 3 && c < 60) begin tick(); c++; end
        total += 4;
        if (launches.size() < 3) begin bad++; $display("FAIL idle_launches: got %0d launches required 3", launches.size()); end
        if (init_done !== 1'b1)  begin bad++; $display("FAIL init_done: got %b required 1", init_done); end
        if (rsps.size() != 0)    begin bad++; $display("FAIL idle_rsp: got %0d responses required 0", rsps.size()); end
        if (txn_cnt !== 16'h0)   begin bad++; $display("FAIL idle_txn: got %h required 0000", txn_cnt); end
        foreach (launches[i]) begin
            total++;
            if (launches[i].addr !== 11'h000) begin
                bad++;
                $display("FAIL idle_addr: launch %0d got %h required 000", i, launches[i].addr);
            end
        end
        $display("test_reset: %0d dummy launches, txn_cnt=%h", launches.size(), txn_cnt);
    endtask

    task automatic test_single_write();
        int w, nreal;
        launches.delete();
        rsps.delete();
        push(1'b1, 10'h014, 16'hA55A, w);
        wait_rsps(1, 40);
        nreal = 0;
        foreach (launches[i]) begin
            if (launches[i].addr !== 11'h000) begin
                nreal++;
                total += 3;
                if (launches[i].addr !== 11'h414) begin bad++; $display("FAIL wr_ctrl_addr: got %h required 414", launches[i].addr); end
                if (launches[i].wdata !== 16'hA55A) begin bad++; $display("FAIL wr_ctrl_data: got %h required a55a", launches[i].wdata); end
                if (!launches[i].stable) begin bad++; $display("FAIL wr_stable: got unstable required stable"); end
            end
        end
        total++;
        if (nreal != 1) begin bad++; $display("FAIL wr_launch_cnt: got %0d required 1", nreal); end
        if (rsps.size() > 0) begin
            total += 3;
            if (rsps[0].wr !== 1'b1)     begin bad++; $display("FAIL wr_rsp_wr: got %b required 1", rsps[0].wr); end
            if (rsps[0].data !== 16'h0)  begin bad++; $display("FAIL wr_rsp_data: got %h required 0000", rsps[0].data); end
            if (rsps[0].cnt !== 16'h1)   begin bad++; $display("FAIL wr_txn: got %h required 0001", rsps[0].cnt); end
            $display("test_single_write: rsp wr=%b data=%h txn=%h", rsps[0].wr, rsps[0].data, rsps[0].cnt);
        end
        repeat (10) tick();
        total++;
        if (rsps.size() != 1) begin bad++; $display("FAIL wr_rsp_cnt: got %0d required 1", rsps.size()); end
    endtask

    task automatic test_single_read();
        int w;
        rsps.delete();
        push(1'b0, 10'h0FE, 16'h1234, w);
        wait_rsps(1, 40);
        if (rsps.size() > 0) begin
            total += 3;
            if (rsps[0].wr !== 1'b0)       begin bad++; $display("FAIL rd_rsp_wr: got %b required 0", rsps[0].wr); end
            if (rsps[0].data !== 16'h00FE) begin bad++; $display("FAIL rd_rsp_data: got %h required 00fe", rsps[0].data); end
            if (rsps[0].cnt !== 16'h2)     begin bad++; $display("FAIL rd_txn: got %h required 0002", rsps[0].cnt); end
            $display("test_single_read: rsp wr=%b data=%h txn=%h", rsps[0].wr, rsps[0].data, rsps[0].cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic        wr_v [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [9:0]  ad_v [6] = '{10'h021, 10'h022, 10'h023, 10'h3FF, 10'h200, 10'h155};
        logic [15:0] wd_v [6] = '{16'h1111, 16'h0000, 16'h3333, 16'h0000, 16'hBEEF, 16'h0000};
        logic [15:0] rd_v [6] = '{16'h0000, 16'h0022, 16'h0000, 16'h03FF, 16'h0000, 16'h0155};
        int w;
        apply_reset();
        wait_idle();
        launches.delete();
        rsps.delete();
        for (int i = 0; i < 4; i++) begin
            push(wr_v[i], ad_v[i], wd_v[i], w);
            total++;
            if (w != 0) begin bad++; $display("FAIL b2b_accept%0d: got wait %0d required 0", i, w); end
        end
        total++;
        if (req_ready !== 1'b0) begin bad++; $display("FAIL b2b_full: got req_ready %b required 0", req_ready); end
        push(wr_v[4], ad_v[4], wd_v[4], w);
        total++;
        if (w != 3) begin bad++; $display("FAIL b2b_wait5: got %0d required 3", w); end
        push(wr_v[5], ad_v[5], wd_v[5], w);
        total++;
        if (w != 6) begin bad++; $display("FAIL b2b_wait6: got %0d required 6", w); end
        wait_rsps(6, 80);
        repeat (3) tick();
        total++;
        if (launches.size() < 8) begin
            bad++;
            $display("FAIL b2b_launches: got %0d required at least 8", launches.size());
        end else begin
            total += 2;
            if (launches[0].addr !== 11'h000) begin bad++; $display("FAIL b2b_first_dummy: got %h required 000", launches[0].addr); end
            if (launches[7].addr !== 11'h000) begin bad++; $display("FAIL b2b_last_dummy: got %h required 000", launches[7].addr); end
            for (int i = 0; i < 6; i++) begin
                total += 3;
                if (launches[i+1].addr !== {wr_v[i], ad_v[i]}) begin bad++; $display("FAIL b2b_addr%0d: got %h required %h", i, launches[i+1].addr, {wr_v[i], ad_v[i]}); end
                if (launches[i+1].wdata !== wd_v[i]) begin bad++; $display("FAIL b2b_wdata%0d: got %h required %h", i, launches[i+1].wdata, wd_v[i]); end
                if (!launches[i+1].stable) begin bad++; $display("FAIL b2b_stable%0d: got unstable required stable", i); end
            end
        end
        for (int i = 0; i < 6 && i < rsps.size(); i++) begin
            total += 3;
            if (rsps[i].wr !== wr_v[i])   begin bad++; $display("FAIL b2b_rsp_wr%0d: got %b required %b", i, rsps[i].wr, wr_v[i]); end
            if (rsps[i].data !== rd_v[i]) begin bad++; $display("FAIL b2b_rsp_data%0d: got %h required %h", i, rsps[i].data, rd_v[i]); end
            if (rsps[i].cnt !== 16'(i + 1)) begin bad++; $display("FAIL b2b_txn%0d: got %h required %h", i, rsps[i].cnt, 16'(i + 1)); end
            if (i > 0) begin
                total++;
                if (rsps[i].cyc - rsps[i-1].cyc != 7) begin bad++; $display("FAIL b2b_period%0d: got %0d cycles required 7", i, rsps[i].cyc - rsps[i-1].cyc); end
            end
            $display("test_back_to_back: rsp %0d wr=%b data=%h txn=%h cyc=%0d", i, rsps[i].wr, rsps[i].data, rsps[i].cnt, rsps[i].cyc);
        end
        total++;
        if (txn_cnt !== 16'h6) begin bad++; $display("FAIL b2b_txn_final: got %h required 0006", txn_cnt); end
    endtask

    task automatic test_reset_mid();
        int w;
        wait_idle();
        for (int i = 0; i < 4; i++) push(1'b1, 10'h030 + 10'(i), 16'h5000 + 16'(i), w);
        repeat (5) tick();
        total++;
        if (ctrl_addr !== 11'h430) begin bad++; $display("FAIL mid_in_write: got %h required 430", ctrl_addr); end
        rst_n = 1'b0;
        #1;
        total += 7;
        if (req_ready !== 1'b1)     begin bad++; $display("FAIL mid_req_ready: got %b required 1", req_ready); end
        if (rsp_valid !== 1'b0)     begin bad++; $display("FAIL mid_rsp_valid: got %b required 0", rsp_valid); end
        if (rsp_wr !== 1'b0)        begin bad++; $display("FAIL mid_rsp_wr: got %b required 0", rsp_wr); end
        if (txn_cnt !== 16'h0)      begin bad++; $display("FAIL mid_txn: got %h required 0000", txn_cnt); end
        if (init_done !== 1'b0)     begin bad++; $display("FAIL mid_init: got %b required 0", init_done); end
        if (ctrl_addr !== 11'h000)  begin bad++; $display("FAIL mid_ctrl_addr: got %h required 000", ctrl_addr); end
        if (ctrl_wr_data !== 16'h0) begin bad++; $display("FAIL mid_ctrl_wdata: got %h required 0000", ctrl_wr_data); end
        repeat (3) tick();
        launches.delete();
        rsps.delete();
        rst_n = 1'b1;
        repeat (50) tick();
        total += 2;
        if (rsps.size() != 0) begin bad++; $display("FAIL mid_no_rsp: got %0d responses required 0", rsps.size()); end
        if (txn_cnt !== 16'h0) begin bad++; $display("FAIL mid_txn_after: got %h required 0000", txn_cnt); end
        foreach (launches[i]) begin
            total++;
            if (launches[i].addr !== 11'h000) begin bad++; $display("FAIL mid_discard: launch %0d got %h required 000", i, launches[i].addr); end
        end
        $display("test_reset_mid: %0d launches after reset, txn_cnt=%h", launches.size(), txn_cnt);
    endtask

    task automatic test_wrap();
        logic [15:0] exp_c [3] = '{16'hFFFF, 16'h0000, 16'h0001};
        int w;
        apply_reset();
        tick();
        force dut.txn_cnt_reg = 16'hFFFE;
        tick();
        release dut.txn_cnt_reg;
        tick();
        total++;
        if (txn_cnt !== 16'hFFFE) begin bad++; $display("FAIL wrap_preload: got %h required fffe", txn_cnt); end
        rsps.delete();
        for (int i = 0; i < 3; i++) push(1'b0, 10'h100 + 10'(i), 16'h0000, w);
        wait_rsps(3, 80);
        for (int i = 0; i < 3 && i < rsps.size(); i++) begin
            total += 2;
            if (rsps[i].cnt !== exp_c[i]) begin bad++; $display("FAIL wrap_cnt%0d: got %h required %h", i, rsps[i].cnt, exp_c[i]); end
            if (rsps[i].data !== 16'h0100 + 16'(i)) begin bad++; $display("FAIL wrap_data%0d: got %h required %h", i, rsps[i].data, 16'h0100 + 16'(i)); end
            $display("test_wrap: rsp %0d data=%h txn=%h", i, rsps[i].data, rsps[i].cnt);
        end
        total++;
        if (txn_cnt !== 16'h0001) begin bad++; $display("FAIL wrap_final: got %h required 0001", txn_cnt); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
